// File: rtl/mlp_ctrl_pkg.sv
// Shared definitions for the MLP control slice: default widths, the NoC flit
// layout and the ReLU enable encoding.
package mlp_ctrl_pkg;

    localparam int DATAW_DEF = 32;
    localparam int LANES_DEF = 4;
    localparam int DESTW_DEF = 4;

    // Flit layout as stored in the buffer: destination above last above lanes.
    typedef struct packed {
        logic [DESTW_DEF-1:0]           dest;
        logic                           last;
        logic [DATAW_DEF*LANES_DEF-1:0] data;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

    localparam logic RELU_ON  = 1'b1;
    localparam logic RELU_OFF = 1'b0;

    // Flit width for non-default parameterisations of the packer.
    function automatic int flit_width(input int dataw, input int lanes, input int destw);
        return destw + 1 + dataw * lanes;
    endfunction

endpackage

// File: rtl/accum_result_packer_flit_fifo.sv
// Synchronous flit FIFO with registered storage and first-word fall-through;
// the head entry is presented combinationally whenever the FIFO is non-empty.
module flit_fifo
    import mlp_ctrl_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Storage is not reset, so the output is forced to zero while empty.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/accum_result_packer.sv
// Packs accumulator results (optionally ReLU-clamped) into LANES-wide NoC flits
// tagged with destination and end-of-vector, buffered so the NoC never stalls input.
module accum_result_packer
    import mlp_ctrl_pkg::*;
#(
    parameter int DATAW      = DATAW_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int DESTW      = DESTW_DEF,
    parameter int CNTW       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [DATAW-1:0]       i_data,
    input  logic                   cfg_relu,
    input  logic [CNTW-1:0]        cfg_count,
    input  logic [DESTW-1:0]       cfg_dest,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [DATAW*LANES-1:0] o_data,
    output logic                   o_last,
    output logic [DESTW-1:0]       o_dest,
    output logic                   o_overflow
);

    localparam int LANEW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FW    = flit_width(DATAW, LANES, DESTW);

    logic [LANEW-1:0]       r_lane_idx;
    logic [CNTW-1:0]        r_elem_cnt;
    logic [DATAW*LANES-1:0] r_pack;
    logic [CNTW-1:0]        r_cnt_lat;
    logic [DESTW-1:0]       r_dest_lat;
    logic                   r_relu_lat;
    logic                   r_overflow;

    logic                   w_first;
    logic [CNTW-1:0]        w_count_sel;
    logic [CNTW-1:0]        w_count_eff;
    logic [DESTW-1:0]       w_dest_eff;
    logic                   w_relu_eff;
    logic [DATAW-1:0]       w_value;
    logic                   w_eov;
    logic                   w_lane_full;
    logic                   w_flit_done;
    logic [DATAW*LANES-1:0] w_flit_data;
    logic [FW-1:0]          w_push_flit;
    logic [FW-1:0]          w_head_flit;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;

    // The first element of a vector uses live config; later elements use the latch.
    assign w_first     = (r_elem_cnt == '0);
    assign w_count_sel = w_first ? cfg_count : r_cnt_lat;
    assign w_count_eff = (w_count_sel == '0) ? CNTW'(1) : w_count_sel;
    assign w_dest_eff  = w_first ? cfg_dest : r_dest_lat;
    assign w_relu_eff  = w_first ? cfg_relu : r_relu_lat;

    assign w_value = ((w_relu_eff == RELU_ON) && i_data[DATAW-1]) ? '0 : i_data;

    assign w_eov       = (r_elem_cnt == (w_count_eff - 1'b1));
    assign w_lane_full = (r_lane_idx == LANEW'(LANES - 1));
    assign w_flit_done = i_valid && (w_lane_full || w_eov);

    // Lanes past the write index are still zero because the pack clears per flit.
    always_comb begin
        w_flit_data = r_pack;
        w_flit_data[r_lane_idx*DATAW +: DATAW] = w_value;
    end

    assign w_push_flit = {w_dest_eff, w_eov, w_flit_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_idx <= '0;
            r_elem_cnt <= '0;
            r_pack     <= '0;
            r_cnt_lat  <= '0;
            r_dest_lat <= '0;
            r_relu_lat <= RELU_OFF;
        end else if (i_valid) begin
            if (w_first) begin
                r_cnt_lat  <= w_count_eff;
                r_dest_lat <= cfg_dest;
                r_relu_lat <= cfg_relu;
            end
            r_elem_cnt <= w_eov ? '0 : r_elem_cnt + 1'b1;
            if (w_flit_done) begin
                r_lane_idx <= '0;
                r_pack     <= '0;
            end else begin
                r_lane_idx <= r_lane_idx + 1'b1;
                r_pack     <= w_flit_data;
            end
        end
    end

    // Output handshake: a flit moves when o_valid && o_ready; while o_valid is
    // high and o_ready low the head flit is held unchanged and o_valid stays up.
    assign w_pop = !w_empty && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_flit_done && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    flit_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_flit_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_flit_done),
        .i_data  (w_push_flit),
        .i_pop   (w_pop),
        .o_data  (w_head_flit),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_valid    = !w_empty;
    assign o_data     = w_head_flit[DATAW*LANES-1:0];
    assign o_last     = w_head_flit[DATAW*LANES];
    assign o_dest     = w_head_flit[FW-1 -: DESTW];
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_accum_result_packer.sv
// Bench for accum_result_packer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of vectors and flits.
module tb_accum_result_packer;

    localparam int DATAW = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int DESTW = 4;
    localparam int CNTW  = 16;
    localparam int DW    = DATAW * LANES;
    localparam int FW    = DESTW + 1 + DW;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic [DATAW-1:0] i_data;
    logic             cfg_relu;
    logic [CNTW-1:0]  cfg_count;
    logic [DESTW-1:0] cfg_dest;
    logic             o_valid;
    logic             o_ready;
    logic [DW-1:0]    o_data;
    logic             o_last;
    logic [DESTW-1:0] o_dest;
    logic             o_overflow;

    accum_result_packer #(
        .DATAW      (DATAW),
        .LANES      (LANES),
        .FIFO_DEPTH (DEPTH),
        .DESTW      (DESTW),
        .CNTW       (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .cfg_relu   (cfg_relu),
        .cfg_count  (cfg_count),
        .cfg_dest   (cfg_dest),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_dest     (o_dest),
        .o_overflow (o_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard: flits the NoC should see, plus the vector being assembled
    logic [FW-1:0]    exp_q[$];
    logic [DATAW-1:0] cur_q[$];
    int               m_cnt   = 0;
    int               m_count = 1;
    logic [DESTW-1:0] m_dest  = '0;
    logic             m_relu  = 1'b0;
    logic             m_ovf   = 1'b0;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic [DATAW-1:0] d, input logic rdy, input logic r);
        logic [DATAW-1:0] val;
        logic [DW-1:0]    fdata;
        logic             vec_end;
        if (r) begin
            exp_q.delete();
            cur_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            return;
        end
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (v) begin
            if (m_cnt == 0) begin
                m_count = (cfg_count == 0) ? 1 : int'(cfg_count);
                m_dest  = cfg_dest;
                m_relu  = cfg_relu;
            end
            val = (m_relu && d[DATAW-1]) ? '0 : d;
            cur_q.push_back(val);
            m_cnt++;
            vec_end = (m_cnt == m_count);
            if (cur_q.size() == LANES || vec_end) begin
                fdata = '0;
                foreach (cur_q[k]) fdata[k*DATAW +: DATAW] = cur_q[k];
                if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                else exp_q.push_back({m_dest, vec_end, fdata});
                cur_q.delete();
                if (vec_end) m_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("o_valid", o_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check_eq("flit", {o_dest, o_last, o_data}, exp_q[0]);
        check_eq("o_overflow", o_overflow, m_ovf);
    endtask

    // driver: called at a falling edge; checks, drives, clocks, advances model
    task automatic step(input logic v, input logic [DATAW-1:0] d, input logic rdy, input logic r);
        check_outputs();
        i_valid = v;
        i_data  = d;
        o_ready = rdy;
        rst     = r;
        @(posedge clk);
        model_update(v, d, rdy, r);
        @(negedge clk);
    endtask

    task automatic feed(input int n, input logic [DATAW-1:0] base, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, base + DATAW'(i), rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"}, o_valid, 1'b0);
        check_eq({tag, "_data"}, o_data, '0);
        check_eq({tag, "_last"}, o_last, 1'b0);
        check_eq({tag, "_dest"}, o_dest, '0);
        check_eq({tag, "_ovf"}, o_overflow, 1'b0);
    endtask

    logic [DATAW-1:0] relu_in [4];

    initial begin
        relu_in[0] = 32'hFFFF_FFFB;
        relu_in[1] = 32'd7;
        relu_in[2] = 32'h8000_0000;
        relu_in[3] = 32'd3;

        i_valid = 1'b0; i_data = '0; o_ready = 1'b0; rst = 1'b1;
        cfg_relu = 1'b0; cfg_count = 16'd8; cfg_dest = 4'd5;
        @(negedge clk);
        @(negedge clk);
        model_update(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        check_reset_values("reset");

        // two full flits, second marked last
        feed(8, 32'd1, 1'b1);
        idle(3, 1'b1);

        // partial final flit, zero-filled
        cfg_count = 16'd6; cfg_dest = 4'd9;
        feed(6, 32'd10, 1'b1);
        idle(3, 1'b1);

        // ReLU clamp, then pass-through of the same values
        cfg_count = 16'd4; cfg_relu = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, relu_in[i], 1'b1, 1'b0);
        check_eq("relu_flit", o_data, {32'd3, 32'd0, 32'd7, 32'd0});
        idle(2, 1'b1);
        cfg_relu = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, relu_in[i], 1'b1, 1'b0);
        check_eq("pass_flit", o_data, {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB});
        idle(2, 1'b1);

        // stalled NoC: five flits, fifth dropped, then drain
        feed(20, 32'd100, 1'b0);
        check_eq("ovf_set", o_overflow, 1'b1);
        idle(3, 1'b0);
        idle(6, 1'b1);
        check_eq("ovf_sticky", o_overflow, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check_reset_values("ovf_clear");

        // full FIFO, push and pop coincide
        feed(16, 32'd200, 1'b0);
        feed(3, 32'd300, 1'b0);
        step(1'b1, 32'd303, 1'b1, 1'b0);
        check_eq("no_drop", o_overflow, 1'b0);
        idle(6, 1'b1);

        // reset mid-vector discards the partial pack
        cfg_count = 16'd4; cfg_dest = 4'd3;
        feed(2, 32'd50, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        check_reset_values("mid_rst");
        step(1'b1, 32'd9, 1'b1, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd6, 1'b1, 1'b0);
        check_eq("post_rst_flit", {o_last, o_data}, {1'b1, 32'd6, 32'd7, 32'd8, 32'd9});
        idle(2, 1'b1);

        // randomized traffic, config churning mid-vector
        for (int n = 0; n < 600; n++) begin
            cfg_count = CNTW'($urandom_range(0, 9));
            cfg_dest  = DESTW'($urandom_range(0, 15));
            cfg_relu  = ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1) ? $urandom : DATAW'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) == 0));
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
